// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer: chooses the player's animation clip from keycode and
// onPlatform, and steps that clip's frame once per video frame. It also maps
// the current DrawX/DrawY pixel to a sprite ROM word address and a spriteOn flag.
// Optional build macro: FLIP_EN. When it is defined, a facing register mirrors
// the column for left-facing run frames.
module player_anim_sequencer #(
    parameter int unsigned HOLD_TICKS = 6,      // frame ticks per animation frame (1..255)
    parameter logic [20:0] ROM_BASE   = 21'd0   // word offset of the player sheet
) (
    input  logic        Clk,
    input  logic        Reset,                  // asynchronous, active-low
    input  logic        frame_clk,
    input  logic [4:0]  keycode,
    input  logic        onPlatform,
    input  logic [9:0]  PlayerX,
    input  logic [9:0]  PlayerY,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [20:0] spriteAddress,
    output logic        spriteOn,
    output logic [9:0]  PlayerHeight,
    output logic [9:0]  PlayerWidth,
    output logic [2:0]  animState,
    output logic [2:0]  frameIdx
);

    localparam logic [2:0] S_STAND  = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_PRONE  = 3'd2;
    localparam logic [2:0] S_AIM_UP = 3'd3;
    localparam logic [2:0] S_JUMP   = 3'd4;

    // Clip table lookups. Every frame of a clip is W*H words, stored row-major.
    function automatic logic [9:0] clip_width(input logic [2:0] s);
        case (s)
            S_PRONE:          return 10'd48;
            S_JUMP, S_AIM_UP: return 10'd24;
            default:          return 10'd32;
        endcase
    endfunction

    function automatic logic [9:0] clip_height(input logic [2:0] s);
        case (s)
            S_PRONE, S_JUMP: return 10'd24;
            S_AIM_UP:        return 10'd64;
            default:         return 10'd48;
        endcase
    endfunction

    function automatic logic [2:0] clip_frames(input logic [2:0] s);
        case (s)
            S_RUN:   return 3'd6;
            S_JUMP:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [20:0] clip_offset(input logic [2:0] s);
        case (s)
            S_RUN:    return 21'd1536;
            S_PRONE:  return 21'd10752;
            S_JUMP:   return 21'd11904;
            S_AIM_UP: return 21'd14208;
            default:  return 21'd0;
        endcase
    endfunction

    logic        r_sync1, r_sync2, r_sync3;
    logic        w_tick;
    logic [2:0]  w_req;
    logic [2:0]  r_anim_state, r_frame_idx;
    logic [7:0]  r_hold;
    logic [9:0]  r_width, r_height;
    logic [20:0] r_addr;
    logic        r_on;

    // Bring frame_clk into the Clk domain, and keep one extra stage for edge detection.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let each stage take its neighbour's old value, which makes this a true shift chain.
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_tick = r_sync2 & ~r_sync3;

    // Requested clip. Airborne or a jump request takes priority over the move code.
    always_comb begin
        // NOTE: assigning a default before the branches prevents an inferred latch when no branch matches.
        w_req = S_STAND;
        if (!onPlatform || keycode[4]) begin
            w_req = S_JUMP;
        end else begin
            case (keycode[3:0])
                4'd1:                               w_req = S_PRONE;
                4'd3:                               w_req = S_AIM_UP;
                4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: w_req = S_RUN;
                default:                            w_req = S_STAND;
            endcase
        end
    end

    // Animation FSM. It changes clip, or advances the hold counter and frame, once per tick.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_anim_state <= S_STAND;
            r_frame_idx  <= 3'd0;
            r_hold       <= 8'd0;
            r_width      <= 10'd32;
            r_height     <= 10'd48;
        end else if (w_tick) begin
            if (w_req != r_anim_state) begin
                r_anim_state <= w_req;
                r_frame_idx  <= 3'd0;
                r_hold       <= 8'd0;
                r_width      <= clip_width(w_req);
                r_height     <= clip_height(w_req);
            end else if (r_hold == 8'(HOLD_TICKS - 1)) begin
                r_hold      <= 8'd0;
                r_frame_idx <= (r_frame_idx == clip_frames(r_anim_state) - 3'd1)
                               ? 3'd0 : r_frame_idx + 3'd1;
            end else begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    logic [9:0]  w_dx, w_dy, w_col;
    logic [10:0] w_x_end, w_y_end;
    logic        w_inside;
    logic [20:0] w_addr;

`ifdef FLIP_EN
    logic r_face_left;

    // Facing changes only when a run is requested. Keys 4, 6 and 8 face left; 2, 5 and 7 face right.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_face_left <= 1'b0;
        end else if (w_tick && w_req == S_RUN) begin
            r_face_left <= (keycode[3:0] == 4'd4) || (keycode[3:0] == 4'd6) ||
                           (keycode[3:0] == 4'd8);
        end
    end

    assign w_col = r_face_left ? (r_width - 10'd1 - w_dx) : w_dx;
`else
    assign w_col = w_dx;
`endif

    assign w_dx     = DrawX - PlayerX;
    assign w_dy     = DrawY - PlayerY;
    // The far edges are computed in 11 bits so that a sprite near X=1023 cannot wrap and produce a false hit.
    assign w_x_end  = {1'b0, PlayerX} + {1'b0, r_width};
    assign w_y_end  = {1'b0, PlayerY} + {1'b0, r_height};
    assign w_inside = (DrawX >= PlayerX) && ({1'b0, DrawX} < w_x_end) &&
                      (DrawY >= PlayerY) && ({1'b0, DrawY} < w_y_end);
    assign w_addr   = ROM_BASE + clip_offset(r_anim_state)
                    + 21'(r_frame_idx) * (21'(r_width) * 21'(r_height))
                    + 21'(w_dy) * 21'(r_width)
                    + 21'(w_col);

    // Registered pixel lookup. It reads the pre-tick clip/frame, so it lags DrawX/DrawY by one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_on   <= 1'b0;
            r_addr <= 21'd0;
        end else if (w_inside) begin
            r_on   <= 1'b1;
            r_addr <= w_addr;
        end else begin
            r_on   <= 1'b0;
            r_addr <= 21'd0;
        end
    end

    assign spriteAddress = r_addr;
    assign spriteOn      = r_on;
    assign PlayerHeight  = r_height;
    assign PlayerWidth   = r_width;
    assign animState     = r_anim_state;
    assign frameIdx      = r_frame_idx;

endmodule

// File: doc/player_anim_sequencer.md
Name: player_anim_sequencer

Overview:
Producer side of the player sprite path. It turns the movement keycode and the onPlatform flag into an animation clip, steps that clip's frame index once per video frame, and converts the current DrawX/DrawY pixel into a sprite ROM word address plus a spriteOn flag. Its sprite outputs feed the sprite ROM and the colour mapper through the existing address/spriteOn/PlayerHeight/PlayerWidth bus.

Parameters:
HOLD_TICKS, 6, frame ticks each animation frame is held (legal 1..255)
ROM_BASE, 0, 21-bit word offset of the player sheet in sprite ROM

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-low reset
frame_clk  input  1  vsync-derived frame strobe, asynchronous to Clk
keycode  input  5  [4]=jump request, [3:0]=move code
onPlatform  input  1  player feet are on a platform
PlayerX  input  10  sprite top-left X
PlayerY  input  10  sprite top-left Y
DrawX  input  10  current pixel X
DrawY  input  10  current pixel Y
spriteAddress  output  21  sprite ROM word address
spriteOn  output  1  current pixel lies inside the sprite box
PlayerHeight  output  10  height of the active clip
PlayerWidth  output  10  width of the active clip
animState  output  3  active clip: 0 STAND, 1 RUN, 2 PRONE, 3 AIM_UP, 4 JUMP
frameIdx  output  3  frame within the active clip

Behaviour:
- Reset (async, Reset=0): animState=STAND, frameIdx=0, hold counter=0, sync flops=0, spriteAddress=0, spriteOn=0, PlayerWidth=32, PlayerHeight=48. All outputs are registered.
- Clip table (width x height, frames, offset from ROM_BASE):
  - STAND 32x48, 1 frame, offset 0
  - RUN 32x48, 6 frames, offset 1536
  - PRONE 48x24, 1 frame, offset 10752
  - JUMP 24x24, 4 frames, offset 11904
  - AIM_UP 24x64, 1 frame, offset 14208
- Frame size W*H: each frame occupies W*H words, contiguous, row-major.
- Clip request (combinational):
  - JUMP if !onPlatform or keycode[4].
  - Otherwise keycode[3:0]: 1 = PRONE; 3 = AIM_UP; 2, 4, 5, 6, 7, 8 = RUN; 0 and all other codes = STAND.
- Tick generation: frame_clk passes through a two-flop synchronizer. tick = 1-cycle pulse on the synchronized 0->1 edge. If frame_clk is already high at reset release, a tick fires 2-3 cycles later.
- FSM, evaluated only on tick:
  - Requested clip != animState: animState <= request, frameIdx <= 0, hold <= 0, PlayerWidth/PlayerHeight <= table values.
  - Same clip: if hold == HOLD_TICKS-1, then hold <= 0 and frameIdx <= (frameIdx == N-1) ? 0 : frameIdx+1. Otherwise hold <= hold+1.
  - Single-frame clips keep frameIdx at 0.
  - Keycode changes between ticks have no effect until the next tick.
- Pixel path, 1-cycle latency from DrawX/DrawY:
  - col = DrawX-PlayerX, row = DrawY-PlayerY.
  - Bounds compared in 11 bits (PlayerX+W does not wrap). inside = DrawX>=PlayerX && DrawX<PlayerX+W && DrawY>=PlayerY && DrawY<PlayerY+H.
  - inside: spriteOn <= 1, spriteAddress <= ROM_BASE + offset + frameIdx*W*H + row*W + col. All terms are 21-bit unsigned.
  - not inside: spriteOn <= 0, spriteAddress <= 0.
  - The pixel path uses the animState/frameIdx registers. On a tick cycle, the pixel sampled that same cycle uses the pre-tick state.

Optional Feature:
FLIP_EN.
- Defined: a facing register (reset = right) updates on tick only when the request is RUN. Keycodes 4, 6, 8 set left; 2, 5, 7 set right. While facing left, col = W-1-(DrawX-PlayerX).
- Undefined: no facing register; col is never mirrored.

Test Plan:
1. Reset release; keycode=0, onPlatform=1, 3 ticks; PlayerX=100, PlayerY=50, DrawX=105, DrawY=52 -> animState=0, frameIdx=0, next cycle spriteOn=1, spriteAddress=69.
2. keycode=2, HOLD_TICKS=6 -> first tick: animState=1, frameIdx=0. After 6 more ticks frameIdx=1, with pixel (0,0) giving address 3072. After 36 ticks in RUN frameIdx wraps to 0.
3. onPlatform=0, keycode=1 -> JUMP, width 24, height 24. Advance to frame 3; pixel (23,23) -> spriteAddress=14207.
4. STAND, PlayerX=100: DrawX=132 -> spriteOn=0, address=0, while DrawX=131 -> spriteOn=1. PlayerX=630, DrawX=639 -> spriteOn=1, with no wrap false-hit at DrawX=5.
5. RUN at frame 4, assert Reset for one half-cycle -> all outputs immediately reset values (STAND, 32x48, spriteOn=0). Release, then tick with keycode=2 -> RUN, frameIdx=0.
6. FLIP_EN defined, keycode=4, RUN frame 0, DrawX=PlayerX, DrawY=PlayerY -> spriteAddress=1567. Then keycode=5 and one tick -> same pixel gives 1536.
